// File: rtl/apb_slave_responder.sv
// APB slave responder for one Pselx bit; word memory, zero-wait-state Prdata loaded at the setup edge.
// Latency: Prdata valid one edge after setup. Backpressure: none, every access phase completes at once.
module apb_slave_responder #(
  parameter int WIDTH      = 32,
  parameter int SLAVES     = 4,
  parameter int SLAVE_ID   = 0,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic [SLAVES-1:0] Pselx,
  input  logic              Penable,
  input  logic              Pwrite,
  input  logic [WIDTH-1:0]  Paddr,
  input  logic [WIDTH-1:0]  Pwdata,
  output logic [WIDTH-1:0]  Prdata,
  output logic              prot_err,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic [DEPTH_LOG2-1:0] idx;
    logic                  write;
  } xfer_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t state, state_nxt;
  xfer_t  lat;

  logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic                  sel;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  do_setup;
  logic                  do_write;
  logic                  do_read;
  logic                  set_err;

  assign sel = Pselx[SLAVE_ID];
  assign idx = Paddr[DEPTH_LOG2+1:2];

  // Byte lane and out-of-range address bits alias onto the same word.
  logic unused_bits;
  assign unused_bits = ^{Paddr[1:0], Paddr[WIDTH-1:DEPTH_LOG2+2], Pselx};

  always_ff @(posedge Hclk) begin
    if (Hreset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_setup  = 1'b0;
    do_write  = 1'b0;
    do_read   = 1'b0;
    set_err   = 1'b0;
    case (state)
      IDLE: begin
        if (sel && !Penable) begin
          do_setup  = 1'b1;
          state_nxt = ACCESS;
        end else if (sel && Penable) begin
          set_err = 1'b1;
        end
      end
      ACCESS: begin
        if (sel && Penable && idx == lat.idx && Pwrite == lat.write) begin
          do_write  = lat.write;
          do_read   = !lat.write;
          state_nxt = IDLE;
        end else begin
          // A broken access drops the transfer; a fresh setup restarts it.
          set_err = 1'b1;
          if (sel && !Penable) begin
            do_setup  = 1'b1;
            state_nxt = ACCESS;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      lat      <= '0;
      Prdata   <= '0;
      prot_err <= 1'b0;
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (do_setup) begin
        lat.idx   <= idx;
        lat.write <= Pwrite;
        if (!Pwrite) Prdata <= mem[idx];
      end
      if (set_err) prot_err <= 1'b1;
      if (do_write && wr_count != CNT_MAX) wr_count <= wr_count + 16'd1;
      if (do_read  && rd_count != CNT_MAX) rd_count <= rd_count + 16'd1;
    end
  end

  // Memory has no reset; reset at the access edge still blocks the write.
  always_ff @(posedge Hclk) begin
    if (!Hreset && do_write) mem[lat.idx] <= Pwdata;
  end

endmodule

// File: tb/tb_apb_slave_responder.sv
// Directed bench for apb_slave_responder (SLAVE_ID=0): transfers, aliasing, protocol errors, reset, saturation.
module tb_apb_slave_responder;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic [3:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        prot_err;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 Hclk = ~Hclk;

  apb_slave_responder #(
    .WIDTH(32), .SLAVES(4), .SLAVE_ID(0), .DEPTH_LOG2(8)
  ) dut (
    .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata),
    .prot_err(prot_err), .wr_count(wr_count), .rd_count(rd_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic step();
    @(negedge Hclk);
  endtask

  task automatic idle();
    Pselx = 4'b0000; Penable = 1'b0;
    step();
  endtask

  task automatic setup(input logic [3:0] s, input logic wr, input logic [31:0] a, input logic [31:0] d);
    Pselx = s; Penable = 1'b0; Pwrite = wr; Paddr = a; Pwdata = d;
    step();
  endtask

  task automatic access();
    Penable = 1'b1;
    step();
  endtask

  task automatic wr_xfer(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    setup(s, 1'b1, a, d);
    access();
    idle();
  endtask

  initial begin
    Hreset = 1'b1; Pselx = '0; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
    step(); step();
    Hreset = 1'b0;
    chk("reset_prdata", Prdata, 32'h0);
    chk("reset_err", {31'b0, prot_err}, 32'h0);
    chk("reset_wr", {16'b0, wr_count}, 32'h0);
    chk("reset_rd", {16'b0, rd_count}, 32'h0);

    // Plain write to word 4
    wr_xfer(4'b0001, 32'h8000_0010, 32'hDEAD_BEEF);
    chk("wr1_count", {16'b0, wr_count}, 32'd1);
    chk("wr1_prdata", Prdata, 32'h0);
    chk("wr1_err", {31'b0, prot_err}, 32'h0);

    // Read back: data present from the setup edge onward
    setup(4'b0001, 1'b0, 32'h8000_0010, 32'h0);
    chk("rd1_setup", Prdata, 32'hDEAD_BEEF);
    access();
    chk("rd1_access", Prdata, 32'hDEAD_BEEF);
    chk("rd1_count", {16'b0, rd_count}, 32'd1);
    idle();

    // Back-to-back write/read through an aliased word 0
    setup(4'b0001, 1'b1, 32'h8000_0400, 32'h1111_2222);
    access();
    setup(4'b0001, 1'b0, 32'h8000_0000, 32'h0);
    chk("b2b_setup", Prdata, 32'h1111_2222);
    access();
    chk("b2b_access", Prdata, 32'h1111_2222);
    chk("b2b_wr", {16'b0, wr_count}, 32'd2);
    chk("b2b_rd", {16'b0, rd_count}, 32'd2);
    chk("b2b_err", {31'b0, prot_err}, 32'h0);
    idle();

    // Access without setup
    Pselx = 4'b0001; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h8000_0010; Pwdata = 32'h0;
    step();
    chk("nosetup_err", {31'b0, prot_err}, 32'h1);
    chk("nosetup_wr", {16'b0, wr_count}, 32'd2);
    idle();

    // Address moves between setup and access: write dropped
    setup(4'b0001, 1'b1, 32'h8000_0010, 32'hCAFE_F00D);
    Paddr = 32'h8000_0014;
    access();
    chk("addrchg_wr", {16'b0, wr_count}, 32'd2);
    chk("addrchg_err", {31'b0, prot_err}, 32'h1);
    idle();
    setup(4'b0001, 1'b0, 32'h8000_0010, 32'h0);
    access();
    chk("addrchg_mem", Prdata, 32'hDEAD_BEEF);
    chk("addrchg_rd", {16'b0, rd_count}, 32'd3);
    idle();

    // Transfer aimed at another slave is invisible
    wr_xfer(4'b0010, 32'h8000_0010, 32'h1234_5678);
    chk("other_wr", {16'b0, wr_count}, 32'd2);
    chk("other_prdata", Prdata, 32'hDEAD_BEEF);
    setup(4'b0010, 1'b0, 32'h8000_0000, 32'h0);
    access();
    chk("other_rd", {16'b0, rd_count}, 32'd3);
    idle();
    setup(4'b0001, 1'b0, 32'h8000_0010, 32'h0);
    access();
    chk("other_mem", Prdata, 32'hDEAD_BEEF);
    idle();

    // Multi-hot select including our bit is serviced
    wr_xfer(4'b0011, 32'h8000_0030, 32'hA5A5_5A5A);
    setup(4'b0011, 1'b0, 32'h8000_0030, 32'h0);
    access();
    chk("multi_prdata", Prdata, 32'hA5A5_5A5A);
    chk("multi_wr", {16'b0, wr_count}, 32'd3);
    chk("multi_rd", {16'b0, rd_count}, 32'd5);
    idle();

    // Reset lands on the access edge of a write
    setup(4'b0001, 1'b1, 32'h8000_0010, 32'h0BAD_BAD0);
    Penable = 1'b1; Hreset = 1'b1;
    step();
    Hreset = 1'b0;
    chk("midrst_prdata", Prdata, 32'h0);
    chk("midrst_err", {31'b0, prot_err}, 32'h0);
    chk("midrst_wr", {16'b0, wr_count}, 32'h0);
    chk("midrst_rd", {16'b0, rd_count}, 32'h0);
    idle();
    setup(4'b0001, 1'b0, 32'h8000_0010, 32'h0);
    access();
    chk("midrst_mem", Prdata, 32'hDEAD_BEEF);
    chk("midrst_rdcnt", {16'b0, rd_count}, 32'd1);
    idle();

    // Saturation: hold the counter at FFFE across one write, then push past the top
    force dut.wr_count = 16'hFFFE;
    setup(4'b0001, 1'b1, 32'h8000_0040, 32'h1);
    access();
    release dut.wr_count;
    idle();
    for (int i = 0; i < 3; i++) wr_xfer(4'b0001, 32'h8000_0040, 32'h2 + i);
    chk("sat_wr", {16'b0, wr_count}, 32'h0000_FFFF);
    setup(4'b0001, 1'b0, 32'h8000_0040, 32'h0);
    access();
    chk("sat_mem", Prdata, 32'h4);
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
